cart_mapper_detect: RTL and testbench
=====================================

Name: cart_mapper_detect

Overview:
- Watches the ioctl ROM download stream and derives the cartridge descriptors the cartridge ROM stage consumes: auto-detected mapper code, no-mapper page offset and power-of-two ROM size.
- Sits directly upstream of the cartridge ROM/mapper stage, in parallel with the SDRAM/BRAM write path.
- Passive: never stalls ioctl.

Parameters:
- CNT_W, 8, width of each saturating mapper-vote counter.
- MIN_SIZE_LOG2, 13, minimum reported ROM size (8 KB).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_isROM  in  1  high for the duration of a cartridge ROM download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- mapper  out  3  0 unknown, 1 nomapper, 2 gamemaster2, 3 konami, 4 konami SCC, 5 ASCII8, 6 ASCII16, 7 linear 64 KB.
- offset  out  4  no-mapper base in 4 KB pages.
- rom_size  out  25  power-of-two ROM size in bytes.
- valid  out  1  descriptors final for the current image.

Behaviour:
- Reset: mapper=0, offset=0, rom_size=0, valid=0, FSM=IDLE, counters and history cleared.
- Start and end detection:
  - ioctl_isROM is registered once.
  - A rising edge starts a load. A falling edge ends it.
  - A reset during a load returns the FSM to IDLE. Remaining bytes are ignored until the next rising edge.
- FSM:
  - IDLE: wait for rising edge, then go to LOAD. On entry: clear counters, max_addr, header flags, byte history; valid=0.
  - LOAD: accept a byte when ioctl_wr=1. Falling edge goes to SIZE.
  - SIZE: one bit per cycle, 25 cycles.
  - DECIDE: 1 cycle.
  - DONE: valid=1. Outputs hold until the next rising edge, which goes to LOAD.
- Accepted byte:
  - max_addr = max(max_addr, ioctl_addr).
  - 3-byte history shifts in ioctl_dout.
- Header capture:
  - Bytes at addresses 0,1 equal 0x41,0x42 ("AB") set hdr0.
  - The same bytes at 0x4000,0x4001 set hdr4.
  - Byte 0x0003 is latched as init_hi.
- Vote rule: when history[2]==0x32 (LD (nn),A), form target={newest,history[1]}. Counters saturate at 2^CNT_W-1:
  - 0x5000, 0x9000, 0xB000: scc++.
  - 0x4000, 0x8000, 0xA000: konami++.
  - 0x6800, 0x7800: ascii8++.
  - 0x77FF: ascii16++.
  - 0x6000, 0x7000: ascii8++ and ascii16++.
  - Overlapping matches each count.
- SIZE (done by sub-module): rom_size = smallest 2^k ≥ max_addr+1, with k ≥ MIN_SIZE_LOG2. If no bytes were accepted, rom_size = 2^MIN_SIZE_LOG2.
- DECIDE, mapper:
  - rom_size ≤ 32 KB: mapper=1.
  - rom_size == 64 KB and all counters zero: mapper=7.
  - Otherwise: the largest counter wins. Tie priority is scc > konami > ascii8 > ascii16.
  - All counters zero and size > 64 KB: mapper=0.
  - Code 2 is never auto-detected.
- DECIDE, offset:
  - Only when mapper=1: hdr0 and rom_size ≤ 16 KB and init_hi[7:6]==2'b10 gives 8.
  - Else !hdr0 and hdr4 gives 0.
  - Else 4.
  - Any other mapper gives 0.
- Latency: valid rises exactly 27 clk after the registered falling edge of ioctl_isROM.
- Edge cases:
  - ioctl_wr outside ioctl_isROM is ignored.
  - A byte strobe on the same cycle as the falling edge is still accepted.
  - max_addr = 0x1FFFFFF gives rom_size=0 (wrap). This is documented; the loader never exceeds 16 MB.

Decomposition:
- Shared package cart_pkg: MAPPER_UNKNOWN..MAPPER_LINEAR codes (0..7), bank register addresses per mapper, LD_NN_A opcode 0x32.
- Sub-module cart_pow2_round: iterative 25-cycle priority scan of max_addr producing rom_size. Has start/done handshake.

Test Plan:
- 16 KB image, "AB" at 0, init 0x4010, no 0x32 patterns -> mapper=1, offset=4, rom_size=0x4000, valid 27 clk after load end.
- 16 KB image, "AB" at 0, init 0x8010 -> mapper=1, offset=8; 32 KB image with "AB" only at 0x4000 -> offset=0, rom_size=0x8000.
- 128 KB image with 5× "32 00 50", 3× "32 00 90", 2× "32 00 80" -> mapper=4, rom_size=0x20000.
- 256 KB image with 4× "32 00 68" and 4× "32 00 60" -> ascii8=8, ascii16=4 -> mapper=5. Tie case: 3× "32 00 80" + 3× "32 00 B0" -> mapper=4.
- 64 KB pattern-free image -> mapper=7. Max address 0x2FFFF -> rom_size=0x40000, mapper=0.
- Reset asserted mid-LOAD with ioctl_isROM still high -> valid=0, outputs zero, no update until a fresh rising edge. 300 repeats of a scc pattern -> counter saturates at 255, no wrap.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared mapper codes, bank-select addresses and FSM states for the cartridge detection slice.
package cart_pkg;

    typedef enum logic [2:0] {
        MAPPER_UNKNOWN = 3'd0,
        MAPPER_NONE    = 3'd1,
        MAPPER_GM2     = 3'd2,
        MAPPER_KONAMI  = 3'd3,
        MAPPER_SCC     = 3'd4,
        MAPPER_ASCII8  = 3'd5,
        MAPPER_ASCII16 = 3'd6,
        MAPPER_LINEAR  = 3'd7
    } mapper_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SIZE,
        S_DECIDE,
        S_DONE
    } state_e;

    localparam logic [7:0] LD_NN_A = 8'h32;

    // Bank-select register addresses that game code writes with LD (nn),A
    localparam logic [15:0] SCC_BANK_1     = 16'h5000;
    localparam logic [15:0] SCC_BANK_2     = 16'h9000;
    localparam logic [15:0] SCC_BANK_3     = 16'hB000;
    localparam logic [15:0] KONAMI_BANK_1  = 16'h4000;
    localparam logic [15:0] KONAMI_BANK_2  = 16'h8000;
    localparam logic [15:0] KONAMI_BANK_3  = 16'hA000;
    localparam logic [15:0] ASCII8_BANK_2  = 16'h6800;
    localparam logic [15:0] ASCII8_BANK_3  = 16'h7800;
    localparam logic [15:0] ASCII16_BANK_A = 16'h77FF;
    localparam logic [15:0] SHARED_BANK_0  = 16'h6000;
    localparam logic [15:0] SHARED_BANK_1  = 16'h7000;

    typedef struct packed {
        logic scc;
        logic konami;
        logic ascii8;
        logic ascii16;
    } vote_t;

    function automatic vote_t vote_decode(input logic [15:0] target);
        vote_t v;
        v.scc     = (target == SCC_BANK_1) || (target == SCC_BANK_2) || (target == SCC_BANK_3);
        v.konami  = (target == KONAMI_BANK_1) || (target == KONAMI_BANK_2) || (target == KONAMI_BANK_3);
        v.ascii8  = (target == ASCII8_BANK_2) || (target == ASCII8_BANK_3) ||
                    (target == SHARED_BANK_0) || (target == SHARED_BANK_1);
        v.ascii16 = (target == ASCII16_BANK_A) ||
                    (target == SHARED_BANK_0) || (target == SHARED_BANK_1);
        return v;
    endfunction

endpackage

// File: rtl/cart_pow2_round.sv
// Rounds the highest written byte address up to a power-of-two ROM size using a
// one-bit-per-cycle MSB scan (25 scan cycles after start, then a done pulse).
module cart_pow2_round #(
    parameter int MIN_SIZE_LOG2 = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [24:0] max_addr,
    output logic        done,
    output logic [24:0] rom_size
);

    logic [24:0] val;
    logic [4:0]  idx;
    logic [4:0]  msb;
    logic [4:0]  msb_fin;
    logic        busy;
    logic        found;
    logic        hit;
    logic        found_fin;
    logic [5:0]  k;

    assign hit       = val[idx] & ~found;
    assign found_fin = found | hit;
    assign msb_fin   = hit ? idx : msb;

    // 2^(msb+1) is the smallest power of two above max_addr; bit 24 set wraps to 0
    always_comb begin
        k = {1'b0, msb_fin} + 6'd1;
        if (!found_fin || k < 6'(MIN_SIZE_LOG2))
            k = 6'(MIN_SIZE_LOG2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val      <= '0;
            idx      <= '0;
            msb      <= '0;
            busy     <= 1'b0;
            found    <= 1'b0;
            done     <= 1'b0;
            rom_size <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                val   <= max_addr;
                idx   <= 5'd24;
                msb   <= '0;
                found <= 1'b0;
                busy  <= 1'b1;
            end else if (busy) begin
                found <= found_fin;
                msb   <= msb_fin;
                if (idx == 5'd0) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    rom_size <= 25'd1 << k;
                end else begin
                    idx <= idx - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cart_mapper_detect.sv
// Passive snooper on the ioctl ROM download: votes on bank-select writes, tracks
// image extent and header, then publishes mapper/offset/rom_size with valid.
module cart_mapper_detect
    import cart_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int MIN_SIZE_LOG2 = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_isROM,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [2:0]  mapper,
    output logic [3:0]  offset,
    output logic [24:0] rom_size,
    output logic        valid
);

    state_e state, state_nxt;

    logic             isrom_q;
    logic             rise, fall, accept, clear;
    logic [24:0]      max_addr, max_addr_nxt;
    logic [2:0][7:0]  hist;
    logic             vote_pend;
    vote_t            hit;
    logic             hdr0_a, hdr0_b, hdr4_a, hdr4_b;
    logic             hdr0, hdr4;
    logic [1:0]       init_hi;   // only the top two bits of byte 3 matter
    logic [CNT_W-1:0] cnt_scc, cnt_konami, cnt_ascii8, cnt_ascii16;
    logic             pow_start, pow_done;
    logic [24:0]      pow_size;
    mapper_e          best, mapper_dec;
    logic [CNT_W-1:0] best_cnt;
    logic             any_vote;
    logic [3:0]       offset_dec;

    assign rise         = ioctl_isROM & ~isrom_q;
    assign fall         = ~ioctl_isROM & isrom_q;
    assign accept       = (state == S_LOAD) & ioctl_wr;
    assign clear        = rise & ((state == S_IDLE) | (state == S_DONE));
    assign max_addr_nxt = (accept && ioctl_addr > max_addr) ? ioctl_addr : max_addr;
    // Sizer latches max_addr_nxt so a byte landing with the falling edge still counts
    assign pow_start    = (state == S_LOAD) & fall;
    assign hit          = (vote_pend && hist[2] == LD_NN_A) ? vote_decode({hist[0], hist[1]}) : '0;
    assign hdr0         = hdr0_a & hdr0_b;
    assign hdr4         = hdr4_a & hdr4_b;

    cart_pow2_round #(
        .MIN_SIZE_LOG2(MIN_SIZE_LOG2)
    ) u_pow2 (
        .clk      (clk),
        .reset    (reset),
        .start    (pow_start),
        .max_addr (max_addr_nxt),
        .done     (pow_done),
        .rom_size (pow_size)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rise) state_nxt = S_LOAD;
            S_LOAD:   if (fall) state_nxt = S_SIZE;
            S_SIZE:   if (pow_done) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = S_DONE;
            S_DONE:   if (rise) state_nxt = S_LOAD;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strict '>' keeps the scc > konami > ascii8 > ascii16 tie order
    always_comb begin
        best     = MAPPER_SCC;
        best_cnt = cnt_scc;
        if (cnt_konami > best_cnt) begin
            best     = MAPPER_KONAMI;
            best_cnt = cnt_konami;
        end
        if (cnt_ascii8 > best_cnt) begin
            best     = MAPPER_ASCII8;
            best_cnt = cnt_ascii8;
        end
        if (cnt_ascii16 > best_cnt) begin
            best     = MAPPER_ASCII16;
            best_cnt = cnt_ascii16;
        end
        any_vote = |{cnt_scc, cnt_konami, cnt_ascii8, cnt_ascii16};

        if (pow_size <= 25'h8000)
            mapper_dec = MAPPER_NONE;
        else if (!any_vote)
            mapper_dec = (pow_size == 25'h10000) ? MAPPER_LINEAR : MAPPER_UNKNOWN;
        else
            mapper_dec = best;

        offset_dec = 4'd0;
        if (mapper_dec == MAPPER_NONE) begin
            if (hdr0 && pow_size <= 25'h4000 && init_hi == 2'b10)
                offset_dec = 4'd8;
            else if (!hdr0 && hdr4)
                offset_dec = 4'd0;
            else
                offset_dec = 4'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Take the current level so a download in flight is not seen as a new start
            isrom_q     <= ioctl_isROM;
            max_addr    <= '0;
            hist        <= '0;
            vote_pend   <= 1'b0;
            hdr0_a      <= 1'b0;
            hdr0_b      <= 1'b0;
            hdr4_a      <= 1'b0;
            hdr4_b      <= 1'b0;
            init_hi     <= '0;
            cnt_scc     <= '0;
            cnt_konami  <= '0;
            cnt_ascii8  <= '0;
            cnt_ascii16 <= '0;
            mapper      <= '0;
            offset      <= '0;
            rom_size    <= '0;
            valid       <= 1'b0;
        end else begin
            isrom_q <= ioctl_isROM;
            if (clear) begin
                max_addr    <= '0;
                hist        <= '0;
                vote_pend   <= 1'b0;
                hdr0_a      <= 1'b0;
                hdr0_b      <= 1'b0;
                hdr4_a      <= 1'b0;
                hdr4_b      <= 1'b0;
                init_hi     <= '0;
                cnt_scc     <= '0;
                cnt_konami  <= '0;
                cnt_ascii8  <= '0;
                cnt_ascii16 <= '0;
                valid       <= 1'b0;
            end else begin
                max_addr  <= max_addr_nxt;
                vote_pend <= accept;
                if (accept) begin
                    hist <= {hist[1:0], ioctl_dout};
                    if (ioctl_addr == 25'h0000 && ioctl_dout == 8'h41) hdr0_a <= 1'b1;
                    if (ioctl_addr == 25'h0001 && ioctl_dout == 8'h42) hdr0_b <= 1'b1;
                    if (ioctl_addr == 25'h4000 && ioctl_dout == 8'h41) hdr4_a <= 1'b1;
                    if (ioctl_addr == 25'h4001 && ioctl_dout == 8'h42) hdr4_b <= 1'b1;
                    if (ioctl_addr == 25'h0003) init_hi <= ioctl_dout[7:6];
                end
                if (hit.scc     && cnt_scc     != '1) cnt_scc     <= cnt_scc + 1'b1;
                if (hit.konami  && cnt_konami  != '1) cnt_konami  <= cnt_konami + 1'b1;
                if (hit.ascii8  && cnt_ascii8  != '1) cnt_ascii8  <= cnt_ascii8 + 1'b1;
                if (hit.ascii16 && cnt_ascii16 != '1) cnt_ascii16 <= cnt_ascii16 + 1'b1;
                if (state == S_DECIDE) begin
                    mapper   <= mapper_dec;
                    offset   <= offset_dec;
                    rom_size <= pow_size;
                    valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_mapper_detect.sv
// Randomized download streams checked against a stream-level model of the detection rules.
module tb_cart_mapper_detect;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_isROM;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [2:0]  mapper;
    logic [3:0]  offset;
    logic [24:0] rom_size;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    int unsigned  wa[$];
    byte unsigned wd[$];
    int unsigned  cur = 0;
    int unsigned  exp_mapper, exp_offset, exp_size;

    logic [15:0] targets[12] = '{16'h5000, 16'h9000, 16'hB000, 16'h4000, 16'h8000, 16'hA000,
                                 16'h6800, 16'h7800, 16'h77FF, 16'h6000, 16'h7000, 16'h1234};

    cart_mapper_detect #(.CNT_W(8), .MIN_SIZE_LOG2(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .ioctl_isROM (ioctl_isROM),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .mapper      (mapper),
        .offset      (offset),
        .rom_size    (rom_size),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int unsigned a, input byte unsigned d);
        wa.push_back(a);
        wd.push_back(d);
        cur = a + 1;
    endtask

    task automatic pat(input logic [15:0] t, input int n);
        repeat (n) begin
            put(cur, 8'h32);
            put(cur, t[7:0]);
            put(cur, t[15:8]);
        end
    endtask

    task automatic filler(input int n);
        byte unsigned b;
        repeat (n) begin
            b = 8'($urandom);
            if (b == 8'h32) b = 8'h33;
            put(cur, b);
        end
    endtask

    // Expected descriptors straight from the accepted byte stream
    task automatic model();
        int unsigned  mx;
        int           c[4];
        int           codes[4];
        int           best;
        int           k;
        bit           h0a, h0b, h4a, h4b, hdr0, hdr4;
        byte unsigned ih;
        logic [15:0]  t;
        longint unsigned sz;
        mx = 0; ih = 0;
        h0a = 0; h0b = 0; h4a = 0; h4b = 0;
        codes = '{4, 3, 5, 6};
        for (int j = 0; j < 4; j++) c[j] = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] > mx) mx = wa[i];
            if (wa[i] == 0      && wd[i] == 8'h41) h0a = 1;
            if (wa[i] == 1      && wd[i] == 8'h42) h0b = 1;
            if (wa[i] == 'h4000 && wd[i] == 8'h41) h4a = 1;
            if (wa[i] == 'h4001 && wd[i] == 8'h42) h4b = 1;
            if (wa[i] == 3) ih = wd[i];
            if (i >= 2 && wd[i-2] == 8'h32) begin
                t = {wd[i], wd[i-1]};
                case (t)
                    16'h5000, 16'h9000, 16'hB000: c[0]++;
                    16'h4000, 16'h8000, 16'hA000: c[1]++;
                    16'h6800, 16'h7800:           c[2]++;
                    16'h77FF:                     c[3]++;
                    16'h6000, 16'h7000: begin c[2]++; c[3]++; end
                    default: ;
                endcase
            end
        end
        for (int j = 0; j < 4; j++) if (c[j] > 255) c[j] = 255;
        hdr0 = h0a && h0b;
        hdr4 = h4a && h4b;
        k = 13;
        while ((64'd1 << k) < 64'(mx) + 64'd1) k++;
        sz = (64'd1 << k) & 64'h1FF_FFFF;
        exp_size = 32'(sz);
        if (sz <= 64'h8000) exp_mapper = 1;
        else if (c[0] + c[1] + c[2] + c[3] == 0) exp_mapper = (sz == 64'h10000) ? 7 : 0;
        else begin
            best = 0;
            for (int j = 1; j < 4; j++) if (c[j] > c[best]) best = j;
            exp_mapper = codes[best];
        end
        exp_offset = 0;
        if (exp_mapper == 1) begin
            if (hdr0 && sz <= 64'h4000 && (ih >> 6) == 2) exp_offset = 8;
            else if (!hdr0 && hdr4) exp_offset = 0;
            else exp_offset = 4;
        end
    endtask

    task automatic run_load(input string name);
        int lat;
        bit coincide;
        model();
        // strobes with ioctl_isROM low must not touch anything
        repeat ($urandom_range(0, 3)) begin
            ioctl_wr = 1; ioctl_addr = 25'($urandom); ioctl_dout = 8'h32;
            tick();
            ioctl_wr = 0;
        end
        ioctl_isROM = 1;
        tick();
        chk({name, ":valid_clr"}, 32'(valid), 0);
        coincide = (wa.size() > 0) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < wa.size(); i++) begin
            repeat ($urandom_range(0, 1)) tick();
            ioctl_wr = 1; ioctl_addr = 25'(wa[i]); ioctl_dout = wd[i];
            if (coincide && i == wa.size() - 1) ioctl_isROM = 0;
            tick();
            ioctl_wr = 0;
        end
        if (!coincide) begin
            ioctl_isROM = 0;
            tick();
        end
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (valid) lat = n;
        end
        chk({name, ":latency"}, 32'(lat), 27);
        chk({name, ":mapper"}, 32'(mapper), exp_mapper);
        chk({name, ":offset"}, 32'(offset), exp_offset);
        chk({name, ":rom_size"}, 32'(rom_size), exp_size);
        wa.delete(); wd.delete(); cur = 0;
    endtask

    initial begin
        reset = 1; ioctl_isROM = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) tick();
        chk("rst:valid", 32'(valid), 0);
        chk("rst:mapper", 32'(mapper), 0);
        chk("rst:offset", 32'(offset), 0);
        chk("rst:rom_size", 32'(rom_size), 0);
        reset = 0;
        tick();

        put(0, 8'h41); put(1, 8'h42); put(2, 8'h10); put(3, 8'h40); filler(20); put('h3FFF, 8'hFF);
        run_load("nomap16_off4");
        put(0, 8'h41); put(1, 8'h42); put(2, 8'h10); put(3, 8'h80); filler(20); put('h3FFF, 8'hFF);
        run_load("nomap16_off8");
        put(0, 8'h00); filler(10); put('h4000, 8'h41); put('h4001, 8'h42); put('h4002, 8'h10);
        put('h4003, 8'h40); filler(5); put('h7FFF, 8'h00);
        run_load("nomap32_hdr4");

        put(0, 8'h41); put(1, 8'h42); cur = 'h100;
        pat(16'h5000, 5); filler(3); pat(16'h9000, 3); pat(16'h8000, 2); put('h1FFFF, 8'h00);
        run_load("scc128");
        cur = 'h100; pat(16'h6800, 4); pat(16'h6000, 4); put('h3FFFF, 8'h00);
        run_load("ascii8_256");
        cur = 'h100; pat(16'h8000, 3); pat(16'hB000, 3); put('h1FFFF, 8'h00);
        run_load("tie_scc");
        filler(30); put('hFFFF, 8'h00);
        run_load("linear64");
        filler(30); put('h2FFFF, 8'h00);
        run_load("unknown256");
        cur = 'h100; pat(16'h5000, 300); pat(16'h8000, 250); put('h1FFFF, 8'h00);
        run_load("saturate");
        run_load("empty");
        put('h1FF_FFFF, 8'h00);
        run_load("wrap");

        // reset in the middle of a download, ioctl_isROM held high throughout
        ioctl_isROM = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            ioctl_wr = 1; ioctl_addr = 25'(i); ioctl_dout = (i % 3 == 0) ? 8'h32 : 8'h50;
            tick();
        end
        ioctl_wr = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("midrst:valid", 32'(valid), 0);
        chk("midrst:mapper", 32'(mapper), 0);
        chk("midrst:offset", 32'(offset), 0);
        chk("midrst:rom_size", 32'(rom_size), 0);
        for (int i = 0; i < 20; i++) begin
            ioctl_wr = 1; ioctl_addr = 25'('h20000 + i); ioctl_dout = 8'($urandom);
            tick();
        end
        ioctl_wr = 0;
        ioctl_isROM = 0;
        repeat (40) tick();
        chk("midrst:valid_hold", 32'(valid), 0);
        chk("midrst:size_hold", 32'(rom_size), 0);

        for (int r = 0; r < 8; r++) begin
            int k;
            int unsigned mx;
            k  = $urandom_range(13, 18);
            mx = (32'd1 << (k - 1)) + $urandom_range(0, (32'd1 << (k - 1)) - 1);
            if ($urandom_range(0, 1) == 1) begin
                put(0, 8'h41); put(1, 8'h42);
            end else begin
                put(0, 8'($urandom)); put(1, 8'($urandom));
            end
            put(2, 8'($urandom)); put(3, 8'($urandom));
            cur = 16;
            repeat ($urandom_range(0, 6)) begin
                pat(targets[$urandom_range(0, 11)], $urandom_range(1, 3));
                filler($urandom_range(0, 2));
            end
            if (mx > 'h4001 && $urandom_range(0, 1) == 1) begin
                put('h4000, 8'h41); put('h4001, 8'h42);
            end
            put(mx, 8'($urandom));
            run_load($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
